// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: transmit side of the PE operand/fire interface.
// Accepts one LANES-wide operand vector per beat and re-emits lane i delayed
// by i cycles, so wavefronts meet on the diagonal of the array. Each tile is
// sequenced as PE clear, K streamed beats, skew drain, then a done pulse.
// Optional feature: define FEEDER_STALL_CNT_EN to add the stall_cnt port.
module systolic_edge_feeder #(
    parameter int LANES       = 4,
    parameter int DW          = 8,
    parameter int KW          = 8,
    parameter int DRAIN_EXTRA = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_a,
    input  logic [LANES*DW-1:0]   in_w,
    output logic [LANES-1:0]      out_fire,
    output logic [LANES*DW-1:0]   out_a,
    output logic [LANES*DW-1:0]   out_w,
    output logic                  pe_clr_n,
    output logic                  busy,
    output logic                  done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int DRAIN_CYC = LANES - 1 + DRAIN_EXTRA;
    localparam int CW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   beat_cnt;
    logic [CW-1:0]   drain_cnt;
    logic            beat;

    // Handshake and status are pure decodes of the registered state
    assign in_ready = (state == S_STREAM);
    assign beat     = in_valid & in_ready;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign pe_clr_n = (state != S_CLEAR);

    // Tile sequencer: clear, stream K beats, drain the skew, signal done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            k_q       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_q   <= k_len;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    beat_cnt  <= '0;
                    drain_cnt <= '0;
                    state     <= (k_q == '0) ? S_DRAIN : S_STREAM;
                end
                S_STREAM: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == k_q - 1'b1) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    // Counts streaming cycles starved of input, saturating at all-ones
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (state == S_CLEAR) begin
            stall_cnt <= '0;
        end else if (state == S_STREAM && !in_valid && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    // Per-lane skew chains: lane l has l+1 stages, the last one drives the PE edge
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [l:0]         fire_sr;
        logic [l:0][DW-1:0] a_sr;
        logic [l:0][DW-1:0] w_sr;

        // Stage 0 captures on a beat (data held otherwise); all stages shift every cycle
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                fire_sr <= '0;
                a_sr    <= '0;
                w_sr    <= '0;
            end else begin
                fire_sr[0] <= beat;
                if (beat) begin
                    a_sr[0] <= in_a[l*DW +: DW];
                    w_sr[0] <= in_w[l*DW +: DW];
                end
                for (int unsigned j = 1; j <= l; j++) begin
                    fire_sr[j] <= fire_sr[j-1];
                    a_sr[j]    <= a_sr[j-1];
                    w_sr[j]    <= w_sr[j-1];
                end
            end
        end

        assign out_fire[l]         = fire_sr[l];
        assign out_a[l*DW +: DW]   = a_sr[l];
        assign out_w[l*DW +: DW]   = w_sr[l];
    end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Scoreboard bench for systolic_edge_feeder. Each tile's schedule is computed
// up front from k_len and a valid pattern; per-cycle expectations are queued
// by the driver and popped by an independent negedge monitor.
module tb_systolic_edge_feeder;

    localparam int LANES       = 4;
    localparam int DW          = 8;
    localparam int KW          = 8;
    localparam int DRAIN_EXTRA = 4;
    localparam int NDRAIN      = LANES - 1 + DRAIN_EXTRA;
    localparam int MAXE        = 8192;
    localparam int M_RAND = 0, M_FULL = 1, M_PAT = 2;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*DW-1:0]  in_a, in_w;
    logic [LANES-1:0]     out_fire;
    logic [LANES*DW-1:0]  out_a, out_w;
    logic                 pe_clr_n, busy, done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    systolic_edge_feeder #(
        .LANES(LANES), .DW(DW), .KW(KW), .DRAIN_EXTRA(DRAIN_EXTRA)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
        .out_fire(out_fire), .out_a(out_a), .out_w(out_w),
        .pe_clr_n(pe_clr_n), .busy(busy), .done(done)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES-1:0]    fire;
        logic [LANES*DW-1:0] a;
        logic [LANES*DW-1:0] w;
        logic                rdy, clr, busy, done;
        int                  stall;
        logic                chk_stall;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state: per-edge record of what lane inputs were presented
    int                  ecnt = 0;
    int                  rbase = 1;
    logic                hf [MAXE];
    logic [LANES*DW-1:0] ha [MAXE];
    logic [LANES*DW-1:0] hw [MAXE];
    logic [LANES*DW-1:0] held_a = '0, held_w = '0;
    int                  ts = -1000, tS = 0, tzeros = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy_at(input int m);
        return (m >= ts + 1) && (m <= ts + tS);
    endfunction

    // Advance one edge: record the beat decision, queue the expected outputs
    task automatic step();
        exp_t e;
        logic acc;
        int   idx;
        @(posedge clk);
        ecnt++;
        acc = rdy_at(ecnt - 1) && in_valid;
        if (acc) begin
            held_a = in_a;
            held_w = in_w;
        end
        hf[ecnt % MAXE] = acc;
        ha[ecnt % MAXE] = held_a;
        hw[ecnt % MAXE] = held_w;
        e.fire = '0; e.a = '0; e.w = '0;
        for (int i = 0; i < LANES; i++) begin
            idx = ecnt - i;
            if (idx >= rbase) begin
                e.fire[i]       = hf[idx % MAXE];
                e.a[i*DW +: DW] = ha[idx % MAXE][i*DW +: DW];
                e.w[i*DW +: DW] = hw[idx % MAXE][i*DW +: DW];
            end
        end
        e.rdy       = rdy_at(ecnt);
        e.clr       = (ecnt != ts);
        e.busy      = (ecnt >= ts) && (ecnt <= ts + tS + NDRAIN + 1);
        e.done      = (ecnt == ts + tS + NDRAIN + 1);
        e.chk_stall = e.done;
        e.stall     = tzeros;
        sbq.push_back(e);
        #1;
    endtask

    // Run one tile; abort_at >= 0 asserts reset after that many post-start cycles
    task automatic run_tile(input int k, input int mode, input logic [15:0] pat, input int abort_at);
        logic v[$];
        int   ones, n, beatn;
        logic [LANES*DW-1:0] va;
        ones = 0; n = 0;
        while (ones < k) begin
            logic b;
            if (mode == M_PAT)       b = pat[n % 16];
            else if (mode == M_FULL) b = 1'b1;
            else                     b = ($urandom_range(0, 3) != 0);
            v.push_back(b);
            if (b) ones++;
            n++;
        end
        start = 1'b1;
        k_len = KW'(k);
        ts = ecnt + 1;
        tS = v.size();
        tzeros = 0;
        foreach (v[i]) if (!v[i]) tzeros++;
        step();
        beatn = 0;
        for (int r = 0; r < tS + NDRAIN + 2; r++) begin
            if (r == abort_at) begin
                do_reset_mid();
                return;
            end
            start = 1'($urandom_range(0, 1));
            k_len = KW'($urandom);
            in_a  = LANES*DW'($urandom);
            in_w  = LANES*DW'($urandom);
            if (r >= 1 && r <= tS) begin
                in_valid = v[r-1];
                if (mode == M_FULL) begin
                    for (int i = 0; i < LANES; i++) va[i*DW +: DW] = DW'(beatn * 4 + i);
                    in_a = va;
                end
                if (v[r-1]) beatn++;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
            end
            step();
        end
        start = 1'b0;
        for (int r = 0; r < 1 + int'($urandom_range(0, 2)); r++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = LANES*DW'($urandom);
            step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fire"}, 32'(out_fire), 32'h0);
        chk({tag, "_a"}, out_a, 32'h0);
        chk({tag, "_w"}, out_w, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'h0);
        chk({tag, "_clr_n"}, 32'(pe_clr_n), 32'h1);
    endtask

    // Asynchronous reset mid-cycle; pending expectations are discarded
    task automatic do_reset_mid();
        #2;
        sbq.delete();
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        start = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'h0);
            chk("midrst_busy", 32'(busy), 32'h0);
        end
        rstn = 1'b1;
        rbase = ecnt + 1;
        held_a = '0; held_w = '0;
        ts = -1000; tS = 0; tzeros = 0;
    endtask

    // Monitor: compares DUT outputs against the queued expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("fire", 32'(out_fire), 32'(e.fire));
                chk("out_a", out_a, e.a);
                chk("out_w", out_w, e.w);
                chk("in_ready", 32'(in_ready), 32'(e.rdy));
                chk("pe_clr_n", 32'(pe_clr_n), 32'(e.clr));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("done", 32'(done), 32'(e.done));
`ifdef FEEDER_STALL_CNT_EN
                if (e.chk_stall) chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
`endif
            end
        end
    end

    initial begin
        rstn = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
        in_a = '0; in_w = '0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run_tile(3, M_FULL, 16'h0, -1);
        run_tile(4, M_PAT, 16'h002D, -1);
        run_tile(0, M_RAND, 16'h0, -1);
        run_tile(8, M_FULL, 16'h0, 4);
        @(posedge clk);
        #1;
        run_tile(2, M_PAT, 16'h0060, -1);
        for (int t = 0; t < 20; t++) begin
            run_tile(int'($urandom_range(0, 12)), M_RAND, 16'h0, -1);
        end
        run_tile(255, M_RAND, 16'h0, -1);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
